// File: rtl/bk_pkg.sv
// Shared constants and types for the BK-0011M mouse port: bit positions in the
// port word and the per-axis pulse FSM states.
package bk_pkg;

    localparam int MS_UP     = 0;
    localparam int MS_RIGHT  = 1;
    localparam int MS_DOWN   = 2;
    localparam int MS_LEFT   = 3;
    localparam int MS_LBTN   = 5;
    localparam int MS_RBTN   = 6;
    localparam int MS_EN_BIT = 3;

    typedef enum logic {
        AX_IDLE = 1'b0,
        AX_HOLD = 1'b1
    } axis_state_t;

endpackage

// File: rtl/bk_mouse_port_if.sv
// Bus bundle between hps_io / CPU port decode (master) and the mouse port (slave).
interface bk_mouse_port_if;

    logic [24:0] ps2_mouse;
    logic        port_write;
    logic        port_wtbt0;
    logic [15:0] port_din;
    logic        joy_any;
    logic [6:0]  mouse_state;
    logic        mouse_active;

    modport master (
        output ps2_mouse, port_write, port_wtbt0, port_din, joy_any,
        input  mouse_state, mouse_active
    );

    modport slave (
        input  ps2_mouse, port_write, port_wtbt0, port_din, joy_any,
        output mouse_state, mouse_active
    );

endinterface

// File: rtl/bk_mouse_axis.sv
// One mouse axis: saturating motion accumulator that converts every THRESH counts
// into a direction pulse held for HOLD_TICKS ce ticks.
module bk_mouse_axis
    import bk_pkg::*;
#(
    parameter int THRESH     = 4,
    parameter int HOLD_TICKS = 3000,
    parameter int ACC_W      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [8:0] delta,
    input  logic       delta_vld,
    input  logic       clr,
    output logic       pos,
    output logic       neg
);

    localparam int SW    = ACC_W + 2;
    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(2 ** (ACC_W - 1));
    localparam logic signed [SW-1:0] TH_P    = SW'(THRESH);
    localparam logic signed [SW-1:0] TH_N    = -SW'(THRESH);

    axis_state_t              state_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [SW-1:0]     acc_ext_s;
    logic signed [SW-1:0]     delta_ext_s;
    logic signed [SW-1:0]     step_s;
    logic signed [SW-1:0]     sum_s;
    logic                     go_pos_s;
    logic                     go_neg_s;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            sat_acc = SAT_MAX[ACC_W-1:0];
        end else if (v < SAT_MIN) begin
            sat_acc = SAT_MIN[ACC_W-1:0];
        end else begin
            sat_acc = v[ACC_W-1:0];
        end
    endfunction

    // Next accumulator value: packet delta and FSM step combine in one update.
    always_comb begin
        acc_ext_s   = {{2{acc_r[ACC_W-1]}}, acc_r};
        delta_ext_s = '0;
        step_s      = '0;
        go_pos_s    = 1'b0;
        go_neg_s    = 1'b0;
        if (delta_vld) begin
            delta_ext_s = {{(SW-9){delta[8]}}, delta};
        end else begin
            delta_ext_s = '0;
        end
        if (state_r == AX_IDLE && acc_ext_s >= TH_P) begin
            go_pos_s = 1'b1;
            step_s   = TH_N;
        end else if (state_r == AX_IDLE && acc_ext_s <= TH_N) begin
            go_neg_s = 1'b1;
            step_s   = TH_P;
        end else begin
            step_s   = '0;
        end
        sum_s = acc_ext_s + delta_ext_s + step_s;
    end

    // Accumulator, pulse FSM and hold counter; clr returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= AX_IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            pos     <= 1'b0;
            neg     <= 1'b0;
        end else if (clr) begin
            state_r <= AX_IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            pos     <= 1'b0;
            neg     <= 1'b0;
        end else begin
            acc_r <= sat_acc(sum_s);
            case (state_r)
                AX_IDLE: begin
                    if (go_pos_s) begin
                        pos     <= 1'b1;
                        cnt_r   <= CNT_W'(HOLD_TICKS - 1);
                        state_r <= AX_HOLD;
                    end else if (go_neg_s) begin
                        neg     <= 1'b1;
                        cnt_r   <= CNT_W'(HOLD_TICKS - 1);
                        state_r <= AX_HOLD;
                    end
                end
                AX_HOLD: begin
                    if (ce) begin
                        if (cnt_r == '0) begin
                            pos     <= 1'b0;
                            neg     <= 1'b0;
                            state_r <= AX_IDLE;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    pos     <= 1'b0;
                    neg     <= 1'b0;
                    state_r <= AX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/bk_mouse_port.sv
// BK-0011M mouse port: turns hps_io PS/2 mouse packets into the 0177714 port
// word (direction pulses + buttons) and the mouse-over-joystick select flag.
module bk_mouse_port
    import bk_pkg::*;
#(
    parameter int THRESH     = 4,
    parameter int HOLD_TICKS = 3000,
    parameter int ACC_W      = 10
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce,
    bk_mouse_port_if.slave   bus
);

    logic       wr_prev_r;
    logic       toggle_r;
    logic       enable_r;
    logic [6:0] ms_r;
    logic       active_r;
    logic       wr_s;
    logic       wr_evt_s;
    logic       clr_s;
    logic       pkt_s;
    logic       vld_s;
    logic [8:0] dx_s;
    logic [8:0] dy_s;
    logic       x_pos_s;
    logic       x_neg_s;
    logic       y_pos_s;
    logic       y_neg_s;
    logic       unused_bits_s;

    assign wr_s     = bus.port_write & bus.port_wtbt0;
    assign wr_evt_s = wr_s & ~wr_prev_r;
    assign clr_s    = wr_evt_s & ~bus.port_din[MS_EN_BIT];
    assign pkt_s    = bus.ps2_mouse[24] ^ toggle_r;
    assign vld_s    = pkt_s & enable_r;
    assign dx_s     = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
    assign dy_s     = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};

    assign unused_bits_s = ^{bus.port_din[15:4], bus.port_din[2:0],
                             bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

    bk_mouse_axis #(.THRESH(THRESH), .HOLD_TICKS(HOLD_TICKS), .ACC_W(ACC_W)) u_axis_x (
        .clk(clk_sys), .rst_n(reset_n), .ce(ce), .delta(dx_s), .delta_vld(vld_s),
        .clr(clr_s), .pos(x_pos_s), .neg(x_neg_s)
    );

    // PS/2 up (positive dy) maps to the port's "up" bit.
    bk_mouse_axis #(.THRESH(THRESH), .HOLD_TICKS(HOLD_TICKS), .ACC_W(ACC_W)) u_axis_y (
        .clk(clk_sys), .rst_n(reset_n), .ce(ce), .delta(dy_s), .delta_vld(vld_s),
        .clr(clr_s), .pos(y_pos_s), .neg(y_neg_s)
    );

    // Write/packet edge detection, enable bit, buttons and port-word packing.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev_r <= 1'b0;
            toggle_r  <= 1'b0;
            enable_r  <= 1'b0;
            ms_r      <= 7'd0;
            active_r  <= 1'b0;
        end else begin
            wr_prev_r <= wr_s;
            toggle_r  <= bus.ps2_mouse[24];
            if (wr_evt_s) begin
                enable_r <= bus.port_din[MS_EN_BIT];
            end
            if (pkt_s) begin
                ms_r[MS_RBTN] <= bus.ps2_mouse[1];
                ms_r[MS_LBTN] <= bus.ps2_mouse[0];
            end
            ms_r[4] <= 1'b0;
            if (clr_s) begin
                ms_r[3:0] <= 4'd0;
            end else begin
                ms_r[MS_LEFT]  <= x_neg_s;
                ms_r[MS_DOWN]  <= y_neg_s;
                ms_r[MS_RIGHT] <= x_pos_s;
                ms_r[MS_UP]    <= y_pos_s;
            end
            // A packet arriving together with joystick activity keeps the mouse selected.
            if (pkt_s) begin
                active_r <= 1'b1;
            end else if (bus.joy_any) begin
                active_r <= 1'b0;
            end
        end
    end

    assign bus.mouse_state  = ms_r;
    assign bus.mouse_active = active_r;

endmodule

// File: tb/tb_bk_mouse_port.sv
// Self-checking bench for bk_mouse_port: expected direction pulses are queued
// when packets are sent and matched by a monitor as each pulse ends.
module tb_bk_mouse_port;
    import bk_pkg::*;

    localparam int H  = 8;
    localparam int TH = 4;

    typedef struct {
        int bit_idx;
        int width;   // 0 = pulse expected to be cut short
    } pulse_t;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b0;
    logic   ce      = 1'b0;
    logic   tgl     = 1'b0;
    pulse_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    bk_mouse_port_if bus_if();

    bk_mouse_port #(.THRESH(TH), .HOLD_TICKS(H), .ACC_W(10)) dut (
        .clk_sys(clk),
        .reset_n(reset_n),
        .ce(ce),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ce = ~ce;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int acc_x();
        return int'(dut.u_axis_x.acc_r);
    endfunction

    function automatic int acc_y();
        return int'(dut.u_axis_y.acc_r);
    endfunction

    function automatic int ms();
        return int'(bus_if.mouse_state);
    endfunction

    // Pulse monitor: width counted in ce ticks seen while the bit is high.
    initial begin
        int     width[4];
        logic   prev[4];
        logic   cur;
        logic   ce_at;
        pulse_t e;
        for (int b = 0; b < 4; b++) begin
            width[b] = 0;
            prev[b]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            ce_at = ce;
            #1;
            for (int b = 0; b < 4; b++) begin
                cur = bus_if.mouse_state[b];
                if (cur) begin
                    if (!prev[b]) width[b] = 0;
                    if (ce_at) width[b]++;
                end else if (prev[b]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_unexpected_pulse_bit", b, -1);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("sb_pulse_bit", b, e.bit_idx);
                        if (e.width > 0) check_eq("sb_pulse_width", width[b], e.width);
                        else check_eq("sb_trunc_width_lt_hold", int'(width[b] < H), 1);
                    end
                end
                prev[b] = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cycle(input logic do_pkt, input int dx, input int dy,
                               input logic [1:0] btn, input logic do_wr,
                               input logic [15:0] din, input logic joy);
        logic [8:0] x9;
        logic [8:0] y9;
        x9 = dx[8:0];
        y9 = dy[8:0];
        @(negedge clk);
        if (do_pkt) begin
            tgl = ~tgl;
            bus_if.ps2_mouse = {tgl, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 2'b00, btn};
        end
        bus_if.port_write = do_wr;
        bus_if.port_wtbt0 = do_wr;
        bus_if.port_din   = din;
        bus_if.joy_any    = joy;
        @(posedge clk);
        #1;
        bus_if.port_write = 1'b0;
        bus_if.port_wtbt0 = 1'b0;
        bus_if.joy_any    = 1'b0;
    endtask

    task automatic send_pkt(input int dx, input int dy, input logic [1:0] btn);
        drive_cycle(1'b1, dx, dy, btn, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic port_wr(input logic [15:0] din);
        drive_cycle(1'b0, 0, 0, 2'b00, 1'b1, din, 1'b0);
    endtask

    task automatic wait_ms_bit(input int b, input logic v, input int budget);
        int n;
        n = 0;
        while (bus_if.mouse_state[b] !== v && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("wait_ms_bit", int'(bus_if.mouse_state[b]), int'(v));
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("sb_drain", sb_q.size(), 0);
    endtask

    initial begin
        bus_if.ps2_mouse  = 25'd0;
        bus_if.port_write = 1'b0;
        bus_if.port_wtbt0 = 1'b0;
        bus_if.port_din   = 16'h0000;
        bus_if.joy_any    = 1'b0;
        reset_n = 1'b0;
        tick(3);
        check_eq("rst_mouse_state", ms(), 0);
        check_eq("rst_mouse_active", int'(bus_if.mouse_active), 0);
        check_eq("rst_acc_x", acc_x(), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: enable, dx=+10 -> two right pulses (10->6->2), acc left at 2
        port_wr(16'h0008);
        sb_q.push_back('{MS_RIGHT, H});
        sb_q.push_back('{MS_RIGHT, H});
        send_pkt(10, 0, 2'b00);
        check_eq("t1_acc_after_pkt", acc_x(), 10);
        check_eq("t1_right_not_yet", int'(bus_if.mouse_state[MS_RIGHT]), 0);
        tick(1);
        check_eq("t1_acc_after_decision", acc_x(), 6);
        check_eq("t1_right_still_low", int'(bus_if.mouse_state[MS_RIGHT]), 0);
        tick(1);
        check_eq("t1_right_set", int'(bus_if.mouse_state[MS_RIGHT]), 1);
        wait_sb_empty(200);
        tick(5);
        check_eq("t1_acc_residue", acc_x(), 2);
        check_eq("t1_ms_idle", ms(), 0);
        check_eq("t1_active", int'(bus_if.mouse_active), 1);

        // 2: disabled, dy=+100 with left button -> buttons only
        port_wr(16'h0000);
        send_pkt(0, 100, 2'b01);
        check_eq("t2_ms_btn_only", ms(), 32'h20);
        check_eq("t2_active", int'(bus_if.mouse_active), 1);
        tick(20);
        check_eq("t2_ms_no_dir", ms(), 32'h20);
        check_eq("t2_acc_y", acc_y(), 0);
        check_eq("t2_acc_x_cleared", acc_x(), 0);

        // 3: eight dx=-128 packets saturate at -512; 1 + 512/4 left pulses
        port_wr(16'h0008);
        for (int i = 0; i < 129; i++) sb_q.push_back('{MS_LEFT, H});
        for (int i = 0; i < 8; i++) send_pkt(-128, 0, 2'b00);
        check_eq("t3_acc_saturated", acc_x(), -512);
        wait_sb_empty(5000);
        tick(5);
        check_eq("t3_acc_drained", acc_x(), 0);
        check_eq("t3_ms_idle", ms(), 0);

        // 4: disabling write mid-HOLD on Y with a concurrent packet
        sb_q.push_back('{MS_UP, 0});
        send_pkt(0, 8, 2'b00);
        wait_ms_bit(MS_UP, 1'b1, 20);
        tick(3);
        drive_cycle(1'b1, 0, 50, 2'b10, 1'b1, 16'h0000, 1'b0);
        check_eq("t4_ms_cleared_btn", ms(), 32'h40);
        check_eq("t4_acc_y", acc_y(), 0);
        check_eq("t4_fsm_idle", int'(dut.u_axis_y.state_r), int'(AX_IDLE));
        tick(20);
        check_eq("t4_ms_stays", ms(), 32'h40);
        check_eq("t4_sb_empty", sb_q.size(), 0);

        // 5: joystick activity deselects the mouse; packets reselect it
        drive_cycle(1'b0, 0, 0, 2'b00, 1'b0, 16'h0000, 1'b1);
        check_eq("t5_joy_clears", int'(bus_if.mouse_active), 0);
        tick(1);
        check_eq("t5_stays_clear", int'(bus_if.mouse_active), 0);
        send_pkt(0, 0, 2'b00);
        check_eq("t5_pkt_sets", int'(bus_if.mouse_active), 1);
        check_eq("t5_btn_release", ms(), 0);
        drive_cycle(1'b1, 0, 0, 2'b01, 1'b0, 16'h0000, 1'b1);
        check_eq("t5_pkt_beats_joy", int'(bus_if.mouse_active), 1);
        check_eq("t5_btn_l", ms(), 32'h20);

        // 6: async reset mid-HOLD, then packet with enable back at 0
        port_wr(16'h0008);
        sb_q.push_back('{MS_RIGHT, 0});
        send_pkt(8, 0, 2'b00);
        wait_ms_bit(MS_RIGHT, 1'b1, 20);
        tick(2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_ms", ms(), 0);
        check_eq("t6_rst_active", int'(bus_if.mouse_active), 0);
        check_eq("t6_rst_acc_x", acc_x(), 0);
        tgl = 1'b0;
        bus_if.ps2_mouse = 25'd0;
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        send_pkt(8, 0, 2'b00);
        check_eq("t6_active_after_pkt", int'(bus_if.mouse_active), 1);
        tick(40);
        check_eq("t6_no_dir", ms(), 0);
        check_eq("t6_acc_x", acc_x(), 0);
        check_eq("t6_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
